// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: multi-channel PWM sharing one period counter, with shadow registers committed at period boundaries
module pwm_multi_ch #(
  parameter int CH         = 4,
  parameter int CW         = 8,
  parameter int DEF_PERIOD = 20,
  parameter int DEF_DUTY   = 2
) (
  input  logic             clk1ms,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [CW-1:0]    period_in,
  input  logic [CH*CW-1:0] duty_in,
  output logic [CH-1:0]    pwm,
  output logic [CW-1:0]    counter,
  output logic             period_end,
  output logic [1:0]       state,
  output logic             load_err
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STOP = 2'b10} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      counter_q, counter_d;
  logic [CW-1:0]      period_act_q, period_act_d, period_sh_q, period_sh_d;
  logic [CH*CW-1:0]   duty_act_q, duty_act_d, duty_sh_q, duty_sh_d;
  logic               pending_q, pending_d, load_err_q, load_err_d;
  logic               run, wrap, load_ok, commit;
  // next-state: counting, FSM, shadow capture and boundary commit
  always_comb begin
    run          = state_q != IDLE;
    wrap         = run && counter_q == period_act_q - 1'b1;
    load_ok      = load && period_in >= CW'(2);
    commit       = pending_q && (!run || wrap);
    state_d      = !run ? (enable ? RUN : IDLE) : enable ? RUN : wrap ? IDLE : STOP;
    counter_d    = (!run || wrap) ? '0 : counter_q + 1'b1;
    period_act_d = commit ? period_sh_q : period_act_q;
    duty_act_d   = commit ? duty_sh_q : duty_act_q;
    period_sh_d  = load_ok ? period_in : period_sh_q;
    duty_sh_d    = load_ok ? duty_in : duty_sh_q;
    pending_d    = load_ok || (pending_q && !commit);
    load_err_d   = load && !load_ok;
  end
  // state registers; reset discards any pending shadow and restores defaults
  always_ff @(posedge clk1ms) begin
    if (reset) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      period_act_q <= CW'(DEF_PERIOD);
      period_sh_q  <= CW'(DEF_PERIOD);
      duty_act_q   <= {CH{CW'(DEF_DUTY)}};
      duty_sh_q    <= {CH{CW'(DEF_DUTY)}};
      pending_q    <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      period_act_q <= period_act_d;
      period_sh_q  <= period_sh_d;
      duty_act_q   <= duty_act_d;
      duty_sh_q    <= duty_sh_d;
      pending_q    <= pending_d;
      load_err_q   <= load_err_d;
    end
  end
  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign pwm[i] = run && counter_q < duty_act_q[i*CW +: CW];
  end
  assign counter    = counter_q;
  assign period_end = wrap;
  assign state      = state_q;
  assign load_err   = load_err_q;
endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: directed checks of period/duty programming, load rejection, stop and reset behaviour
module tb_pwm_multi_ch;
  logic        clk1ms = 0, reset = 1, enable = 0, load = 0;
  logic [7:0]  period_in = 0;
  logic [31:0] duty_in = 0;
  logic [3:0]  pwm;
  logic [7:0]  counter;
  logic        period_end, load_err;
  logic [1:0]  state;
  int n_vec = 0, n_err = 0;
  int ec = 0, ep = 20;
  int ed[4] = '{2, 2, 2, 2};

  pwm_multi_ch dut (
    .clk1ms(clk1ms), .reset(reset), .enable(enable), .load(load),
    .period_in(period_in), .duty_in(duty_in), .pwm(pwm), .counter(counter),
    .period_end(period_end), .state(state), .load_err(load_err)
  );

  always #5 clk1ms = ~clk1ms;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1ms);
    #1;
  endtask

  function automatic logic [3:0] epwm();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ec < ed[i];
    return r;
  endfunction

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      chk("counter", counter, ec);
      chk("pwm", pwm, epwm());
      chk("period_end", period_end, ec == ep - 1);
      tick();
      ec = (ec == ep - 1) ? 0 : ec + 1;
    end
  endtask

  initial begin
    tick(); tick();
    reset = 0;
    chk("rst_state", state, 0);
    chk("rst_counter", counter, 0);
    chk("rst_pwm", pwm, 0);
    chk("rst_pend", period_end, 0);
    chk("rst_lerr", load_err, 0);
    tick();
    chk("idle_hold", state, 0);
    // defaults: period 20, duty 2
    enable = 1;
    tick();
    chk("run_state", state, 1);
    run(40);
    // mid-period load: old waveform completes first
    run(5);
    load = 1; period_in = 10; duty_in = {8'd15, 8'd10, 8'd3, 8'd0};
    tick(); ec = 6;
    load = 0;
    chk("no_lerr", load_err, 0);
    run(14);
    ep = 10; ed = '{0, 3, 10, 15};
    run(20);
    // rejected load
    load = 1; period_in = 1; duty_in = '1;
    tick(); ec = 1;
    load = 0;
    chk("lerr_pulse", load_err, 1);
    chk("lerr_counter", counter, 1);
    tick(); ec = 2;
    chk("lerr_clear", load_err, 0);
    run(18);
    // load on the wrap edge commits at the following wrap
    run(9);
    load = 1; period_in = 6; duty_in = {8'd4, 8'd3, 8'd2, 8'd1};
    tick(); ec = 0;
    load = 0;
    run(10);
    ep = 6; ed = '{1, 2, 3, 4};
    run(12);
    // back to period 20, duty 10, then stop mid-period
    load = 1; period_in = 20; duty_in = {4{8'd10}};
    tick(); ec = 1;
    load = 0;
    run(5);
    ep = 20; ed = '{10, 10, 10, 10};
    run(5);
    enable = 0;
    tick(); ec = 6;
    chk("stop_state", state, 2);
    run(14);
    chk("stopped_state", state, 0);
    chk("stopped_counter", counter, 0);
    chk("stopped_pwm", pwm, 0);
    chk("stopped_pend", period_end, 0);
    // reset mid-period with a load pending
    enable = 1;
    tick(); ec = 0;
    chk("restart_state", state, 1);
    run(6);
    load = 1; period_in = 8; duty_in = {4{8'd1}};
    tick();
    load = 0;
    chk("pre_rst_counter", counter, 7);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_counter", counter, 0);
    chk("mid_rst_pwm", pwm, 0);
    chk("mid_rst_pend", period_end, 0);
    tick(); ec = 0;
    ed = '{2, 2, 2, 2};
    chk("post_rst_state", state, 1);
    run(42);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
